vram_fill_engine: RTL and testbench

- Memory-mapped responder on the CPU data bus that owns the VRAM write port.
- Accepts CPU register writes in the 0xC region and fills clipped rectangles of 12-bit pixels into the 640x480 VRAM, one pixel per clock.
- Passes direct CPU pixel writes in the 0xD region through to VRAM while idle.
- Sits between the CPU/bus address and data lines and the VRAM port A. The VGA scanout side, port B, is untouched.

---
 rtl/vram_pkg.sv | 28 ++
 rtl/rect_walker.sv | 60 ++++++
 rtl/vram_fill_engine.sv | 150 +++++++++++++++
 tb/tb_vram_fill_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants, register map and FSM state type for the VRAM fill engine.
package vram_pkg;

  localparam int unsigned H_RES  = 640;
  localparam int unsigned V_RES  = 480;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PIX_W  = 12;

  localparam logic [3:0] REG_NIB  = 4'hC;
  localparam logic [3:0] VRAM_NIB = 4'hD;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_ORG   = 2'd1;
  localparam logic [1:0] REG_SIZE  = 2'd2;
  localparam logic [1:0] REG_COLOR = 2'd3;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_ERR      = 1;
  localparam int unsigned STAT_DONE_LSB = 8;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } fill_state_t;

endpackage

// File: rtl/rect_walker.sv
// Raster walker over a clipped rectangle: produces the linear VRAM address and a last-pixel flag.
module rect_walker
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [10:0]       xe,
  input  logic [9:0]        ye,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [9:0]        x, x0_l;
  logic [8:0]        y;
  logic [10:0]       xe_l;
  logic [9:0]        ye_l;
  logic [ADDR_W-1:0] row_base;

  logic [10:0] x_nx;
  logic [9:0]  y_nx;
  logic        row_end;

  assign x_nx    = {1'b0, x} + 11'd1;
  assign y_nx    = {1'b0, y} + 10'd1;
  assign row_end = (x_nx == xe_l);
  assign last    = row_end && (y_nx == ye_l);
  assign addr    = row_base + ADDR_W'(x);

  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      x0_l     <= '0;
      xe_l     <= '0;
      ye_l     <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= x0;
      y        <= y0;
      x0_l     <= x0;
      xe_l     <= xe;
      ye_l     <= ye;
      row_base <= ADDR_W'(y0) * ADDR_W'(H_RES);
    end else if (step) begin
      // row advance by addition keeps the multiplier out of the per-pixel path
      if (row_end) begin
        x        <= x0_l;
        y        <= y + 9'd1;
        row_base <= row_base + ADDR_W'(H_RES);
      end else begin
        x <= x_nx[9:0];
      end
    end
  end

endmodule

// File: rtl/vram_fill_engine.sv
// CPU-bus responder owning VRAM port A: rectangle fill engine plus direct pixel pass-through.
module vram_fill_engine
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Cpu_data2bus,
  input  logic              mem_w,
  output logic [31:0]       Cpu_data4bus,
  output logic              busy,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [PIX_W-1:0]  vram_din
);

  fill_state_t      state;
  logic [9:0]       org_x0, size_w;
  logic [8:0]       org_y0, size_h;
  logic [PIX_W-1:0] color_r, fill_color;
  logic             err;
  logic [7:0]       done_cnt;

  logic reg_sel, vram_sel, reg_wr, ctrl_wr, abort_req, start_req;
  logic rect_ok, fill_load, direct_wr;
  logic [10:0] x_sum, xe;
  logic [9:0]  y_sum, ye;
  logic [ADDR_W-1:0] walk_addr;
  logic walk_last;
  logic unused_bits;

  assign unused_bits = ^{addr_bus[27:19], Cpu_data2bus[31:25], Cpu_data2bus[15:12]};

  assign reg_sel   = (addr_bus[31:28] == REG_NIB);
  assign vram_sel  = (addr_bus[31:28] == VRAM_NIB);
  assign reg_wr    = mem_w && reg_sel;
  assign ctrl_wr   = reg_wr && (addr_bus[3:2] == REG_CTRL);
  assign abort_req = ctrl_wr && Cpu_data2bus[CTRL_ABORT];
  assign start_req = ctrl_wr && Cpu_data2bus[CTRL_START] && !Cpu_data2bus[CTRL_ABORT];
  assign direct_wr = mem_w && vram_sel;

  assign x_sum   = {1'b0, org_x0} + {1'b0, size_w};
  assign y_sum   = {1'b0, org_y0} + {1'b0, size_h};
  assign xe      = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
  assign ye      = (y_sum > 10'(V_RES)) ? 10'(V_RES) : y_sum;
  assign rect_ok = (org_x0 < 10'(H_RES)) && (org_y0 < 9'(V_RES)) &&
                   (size_w != '0) && (size_h != '0);
  assign fill_load = start_req && (state == S_IDLE) && rect_ok;

  assign busy = (state == S_FILL);

  rect_walker u_walker (
    .clk  (clk),
    .rst  (rst),
    .load (fill_load),
    .x0   (org_x0),
    .y0   (org_y0),
    .xe   (xe),
    .ye   (ye),
    .step (state == S_FILL),
    .addr (walk_addr),
    .last (walk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      org_x0     <= '0;
      org_y0     <= '0;
      size_w     <= '0;
      size_h     <= '0;
      color_r    <= '0;
      fill_color <= '0;
      err        <= 1'b0;
      done_cnt   <= '0;
    end else begin
      if (reg_wr) begin
        case (addr_bus[3:2])
          REG_ORG: begin
            org_x0 <= Cpu_data2bus[9:0];
            org_y0 <= Cpu_data2bus[24:16];
          end
          REG_SIZE: begin
            size_w <= Cpu_data2bus[9:0];
            size_h <= Cpu_data2bus[24:16];
          end
          REG_COLOR: color_r <= Cpu_data2bus[PIX_W-1:0];
          default: ;
        endcase
      end

      // an abort landing on the last pixel still suppresses the completion count
      if (state == S_FILL && walk_last) begin
        state <= S_IDLE;
        if (!abort_req) done_cnt <= done_cnt + 8'd1;
      end

      if (ctrl_wr) begin
        if (abort_req) begin
          state <= S_IDLE;
        end else if (start_req) begin
          if (state == S_FILL) begin
            err <= 1'b1;
          end else if (rect_ok) begin
            state      <= S_FILL;
            fill_color <= color_r;
          end else begin
            done_cnt <= done_cnt + 8'd1;
          end
        end else begin
          err <= 1'b0;
        end
      end

      if (direct_wr && state == S_FILL) err <= 1'b1;
    end
  end

  always_comb begin
    vram_we   = 1'b0;
    vram_addr = '0;
    vram_din  = '0;
    if (state == S_FILL) begin
      vram_we   = 1'b1;
      vram_addr = walk_addr;
      vram_din  = fill_color;
    end else if (direct_wr) begin
      vram_we   = 1'b1;
      vram_addr = addr_bus[ADDR_W-1:0];
      vram_din  = Cpu_data2bus[PIX_W-1:0];
    end
  end

  always_comb begin
    Cpu_data4bus = '0;
    if (reg_sel) begin
      case (addr_bus[3:2])
        REG_CTRL: begin
          Cpu_data4bus[STAT_BUSY] = busy;
          Cpu_data4bus[STAT_ERR]  = err;
          Cpu_data4bus[STAT_DONE_LSB +: 8] = done_cnt;
        end
        REG_ORG:   Cpu_data4bus = {7'b0, org_y0, 6'b0, org_x0};
        REG_SIZE:  Cpu_data4bus = {7'b0, size_h, 6'b0, size_w};
        default:   Cpu_data4bus = {20'b0, color_r};
      endcase
    end
  end

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine against a pixel-list reference model.
module tb_vram_fill_engine;

  localparam int HR = 640;
  localparam int VR = 480;
  localparam logic [31:0] A_CTRL  = 32'hC000_0000;
  localparam logic [31:0] A_ORG   = 32'hC000_0004;
  localparam logic [31:0] A_SIZE  = 32'hC000_0008;
  localparam logic [31:0] A_COLOR = 32'hC000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_bus;
  logic [31:0] wdata;
  logic        mem_w;
  logic [31:0] rd_data;
  logic        busy;
  logic        vram_we;
  logic [18:0] vram_addr;
  logic [11:0] vram_din;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_done = '0;
  logic       exp_err  = 1'b0;

  vram_fill_engine dut (
    .clk          (clk),
    .rst          (rst),
    .addr_bus     (addr_bus),
    .Cpu_data2bus (wdata),
    .mem_w        (mem_w),
    .Cpu_data4bus (rd_data),
    .busy         (busy),
    .vram_we      (vram_we),
    .vram_addr    (vram_addr),
    .vram_din     (vram_din)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_bus = a; wdata = d; mem_w = 1'b1;
    @(negedge clk);
    mem_w = 1'b0; addr_bus = '0; wdata = '0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] v);
    addr_bus = a; mem_w = 1'b0;
    #1;
    v = rd_data;
    addr_bus = '0;
  endtask

  function automatic logic [31:0] exp_status();
    return {16'b0, exp_done, 6'b0, exp_err, 1'b0};
  endfunction

  // Reference: list of linear addresses covered by the on-screen part of the rectangle.
  task automatic model_pixels(input int x0, input int y0, input int w, input int h,
                              output int q[$]);
    q = {};
    if (x0 < HR && y0 < VR)
      for (int yy = y0; yy < y0 + h && yy < VR; yy++)
        for (int xx = x0; xx < x0 + w && xx < HR; xx++)
          q.push_back(yy * HR + xx);
  endtask

  task automatic run_fill(input int x0, input int y0, input int w, input int h,
                          input logic [11:0] col, input string tag);
    int q[$];
    logic [31:0] st;
    model_pixels(x0, y0, w, h, q);
    bus_write(A_ORG,   32'((y0 << 16) | x0));
    bus_write(A_SIZE,  32'((h << 16) | w));
    bus_write(A_COLOR, {20'b0, col});
    bus_write(A_CTRL,  32'h1);
    if (q.size() == 0) begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (busy !== 1'b0 || vram_we !== 1'b0) begin
          errors++;
          $display("FAIL %s degenerate cyc%0d: busy=%b we=%b, want 0 0", tag, i, busy, vram_we);
        end
        @(negedge clk);
      end
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (busy !== 1'b1 || vram_we !== 1'b1 || vram_addr !== 19'(q[i]) || vram_din !== col) begin
          errors++;
          $display("FAIL %s pixel%0d: busy=%b we=%b addr=%0d din=%h, want 1 1 %0d %h",
                   tag, i, busy, vram_we, vram_addr, vram_din, q[i], col);
        end
        @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0 || vram_we !== 1'b0) begin
        errors++;
        $display("FAIL %s end: busy=%b we=%b, want 0 0", tag, busy, vram_we);
      end
    end
    exp_done = exp_done + 8'd1;
    read_reg(A_CTRL, st);
    checks++;
    if (st !== exp_status()) begin
      errors++;
      $display("FAIL %s status: got %h want %h", tag, st, exp_status());
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; mem_w = 1'b0; addr_bus = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vram_we !== 1'b0 || vram_addr !== '0 || vram_din !== '0) begin
      errors++;
      $display("FAIL reset outputs: busy=%b we=%b addr=%0d din=%h, want 0", busy, vram_we, vram_addr, vram_din);
    end
    rst = 1'b0;
    @(negedge clk);
    read_reg(A_CTRL, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset status: got %h want 0", v); end
    read_reg(A_ORG, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset org: got %h want 0", v); end
    read_reg(A_SIZE, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset size: got %h want 0", v); end
    read_reg(A_COLOR, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset color: got %h want 0", v); end
  endtask

  task automatic test_basic_fill();
    run_fill(10, 2, 3, 2, 12'hF0F, "basic");
  endtask

  task automatic test_clip();
    run_fill(638, 479, 5, 5, 12'h5A3, "clip");
    run_fill(0, 478, 2, 9, 12'h0C1, "clip_bottom");
  endtask

  task automatic test_degenerate();
    run_fill(5, 5, 0, 4, 12'h111, "w0");
    run_fill(5, 5, 4, 0, 12'h222, "h0");
    run_fill(640, 0, 3, 3, 12'h333, "xoff");
    run_fill(0, 480, 3, 3, 12'h444, "yoff");
  endtask

  task automatic test_random();
    logic [31:0] d, v;
    for (int n = 0; n < 10; n++) begin
      int x0, y0, w, h;
      d = $urandom;
      bus_write(A_ORG, d);
      read_reg(A_ORG, v);
      checks++;
      if (v !== (d & 32'h01FF_03FF)) begin
        errors++; $display("FAIL rand org readback: got %h want %h", v, d & 32'h01FF_03FF);
      end
      d = $urandom;
      bus_write(A_COLOR, d);
      read_reg(A_COLOR, v);
      checks++;
      if (v !== (d & 32'h0000_0FFF)) begin
        errors++; $display("FAIL rand color readback: got %h want %h", v, d & 32'h0000_0FFF);
      end
      x0 = (n % 2 == 1) ? int'($urandom_range(625, 645)) : int'($urandom_range(0, 700));
      y0 = (n % 3 == 2) ? int'($urandom_range(470, 485)) : int'($urandom_range(0, 500));
      w  = $urandom_range(0, 12);
      h  = $urandom_range(0, 5);
      run_fill(x0, y0, w, h, 12'($urandom), "random");
    end
  endtask

  task automatic test_direct();
    logic [31:0] a, d;
    @(negedge clk);
    addr_bus = 32'hD000_0064; wdata = 32'h0000_0ABC; mem_w = 1'b1;
    #1;
    checks++;
    if (vram_we !== 1'b1 || vram_addr !== 19'd100 || vram_din !== 12'hABC) begin
      errors++;
      $display("FAIL direct: we=%b addr=%0d din=%h, want 1 100 abc", vram_we, vram_addr, vram_din);
    end
    mem_w = 1'b0;
    #1;
    checks++;
    if (vram_we !== 1'b0) begin errors++; $display("FAIL direct no strobe: we=%b want 0", vram_we); end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      a = {4'hD, 9'($urandom), 19'($urandom)};
      d = $urandom;
      addr_bus = a; wdata = d; mem_w = 1'b1;
      #1;
      checks++;
      if (vram_we !== 1'b1 || vram_addr !== a[18:0] || vram_din !== d[11:0]) begin
        errors++;
        $display("FAIL direct rand: we=%b addr=%0d din=%h, want 1 %0d %h",
                 vram_we, vram_addr, vram_din, a[18:0], d[11:0]);
      end
    end
    @(negedge clk);
    mem_w = 1'b0; addr_bus = '0; wdata = '0;
  endtask

  // Fill from (20,3), 100x100: pixel k sits at 3*640+20+k for the first row.
  task automatic test_abort_and_err();
    logic [31:0] st;
    logic [11:0] col;
    int base;
    col  = 12'($urandom);
    base = 3 * HR + 20;
    bus_write(A_ORG,   32'((3 << 16) | 20));
    bus_write(A_SIZE,  32'((100 << 16) | 100));
    bus_write(A_COLOR, {20'b0, col});
    bus_write(A_CTRL,  32'h1);
    for (int k = 0; k < 40; k++) begin
      mem_w = 1'b0; addr_bus = A_CTRL; wdata = '0;
      #1;
      checks++;
      if (k < 17) begin
        if (busy !== 1'b1 || vram_we !== 1'b1 || vram_addr !== 19'(base + k) || vram_din !== col) begin
          errors++;
          $display("FAIL abort pixel%0d: busy=%b we=%b addr=%0d din=%h, want 1 1 %0d %h",
                   k, busy, vram_we, vram_addr, vram_din, base + k, col);
        end
      end else if (busy !== 1'b0 || vram_we !== 1'b0) begin
        errors++;
        $display("FAIL after abort cyc%0d: busy=%b we=%b, want 0 0", k, busy, vram_we);
      end
      if (k == 5 || k == 9 || k == 13) begin
        checks++;
        if (rd_data[1] !== (k != 9)) begin
          errors++;
          $display("FAIL err bit cyc%0d: got %b want %b", k, rd_data[1], k != 9);
        end
      end
      case (k)
        3:  begin wdata = 32'h1; mem_w = 1'b1; end
        7:  begin wdata = 32'h0; mem_w = 1'b1; end
        11: begin addr_bus = 32'hD000_0064; wdata = 32'h0000_0ABC; mem_w = 1'b1; end
        16: begin wdata = 32'h2; mem_w = 1'b1; end
        default: ;
      endcase
      #1;
      if (k == 11) begin
        checks++;
        if (vram_addr !== 19'(base + k) || vram_din !== col) begin
          errors++;
          $display("FAIL direct during fill: addr=%0d din=%h, want %0d %h",
                   vram_addr, vram_din, base + k, col);
        end
      end
      @(negedge clk);
    end
    mem_w = 1'b0; addr_bus = '0; wdata = '0;
    exp_err = 1'b1;
    read_reg(A_CTRL, st);
    checks++;
    if (st !== exp_status()) begin
      errors++; $display("FAIL abort status: got %h want %h", st, exp_status());
    end
    bus_write(A_CTRL, 32'h0);
    exp_err = 1'b0;
    read_reg(A_CTRL, st);
    checks++;
    if (st !== exp_status()) begin
      errors++; $display("FAIL err clear: got %h want %h", st, exp_status());
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] v;
    bus_write(A_ORG,   32'h0);
    bus_write(A_SIZE,  32'((50 << 16) | 50));
    bus_write(A_COLOR, 32'h777);
    bus_write(A_CTRL,  32'h1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vram_we !== 1'b0) begin
      errors++; $display("FAIL reset mid fill: busy=%b we=%b, want 0 0", busy, vram_we);
    end
    rst = 1'b0;
    exp_done = '0;
    exp_err  = 1'b0;
    @(negedge clk);
    read_reg(A_CTRL, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset mid fill status: got %h want 0", v); end
    read_reg(A_SIZE, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset mid fill size: got %h want 0", v); end
    run_fill(1, 1, 2, 2, 12'hACE, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_clip();
    test_degenerate();
    test_random();
    test_direct();
    test_abort_and_err();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
